// File: rtl/hid_report_uart.sv
// Streams each accepted HID report as one ASCII line "T:HHHHHHHHHHHHHHHH\r\n" over an 8N1 UART.
// Reports that arrive while a line is in flight are dropped and counted (saturating).
module hid_report_uart #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  usb_type,
    input  logic        usb_report,
    input  logic [63:0] hid_report,
    output logic        uart_tx,
    output logic        busy,
    output logic [7:0]  drop_cnt
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [4:0]  char_q, char_d;
    logic [1:0]  typ_q;
    logic [63:0] rpt_q;
    logic [7:0]  drop_q;
    logic        tx_q, tx_d;

    logic        accept, dropReport, baudEnd;
    logic [3:0]  k;
    logic [5:0]  nibIdx;
    logic [3:0]  nib;
    logic [7:0]  charByte;

    function automatic logic [7:0] hexAscii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h37 + {4'b0, n});
    endfunction

    assign busy       = (state_q != IDLE);
    assign accept     = usb_report && !busy && (usb_type != 2'd0);
    assign dropReport = usb_report && busy && (usb_type != 2'd0);
    assign baudEnd    = (baud_q == DIV_M1);

    // Hex chars c2..c17 walk byte 0 upward, high nibble first.
    always_comb begin
        k        = char_q[3:0] - 4'd2;
        nibIdx   = {k[3:1], ~k[0], 2'b00};
        nib      = rpt_q[nibIdx +: 4];
        charByte = hexAscii(nib);
        case (char_q)
            5'd0:    charByte = 8'h30 + {6'b0, typ_q};
            5'd1:    charByte = 8'h3A;
            5'd18:   charByte = 8'h0D;
            5'd19:   charByte = 8'h0A;
            default: charByte = hexAscii(nib);
        endcase
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        char_d  = char_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    char_d  = 5'd0;
                end
            end
            START: begin
                baud_d = baud_q + 16'd1;
                if (baudEnd) begin
                    baud_d  = 16'd0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_q + 16'd1;
                if (baudEnd) begin
                    baud_d = 16'd0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                baud_d = baud_q + 16'd1;
                if (baudEnd) begin
                    baud_d = 16'd0;
                    if (char_q == 5'd19) begin
                        state_d = IDLE;
                    end else begin
                        char_d  = char_q + 5'd1;
                        state_d = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so the pin never glitches.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = charByte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            char_q  <= 5'd0;
            typ_q   <= 2'd0;
            rpt_q   <= 64'd0;
            drop_q  <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            char_q  <= char_d;
            tx_q    <= tx_d;
            if (accept) begin
                typ_q <= usb_type;
                rpt_q <= hid_report;
            end
            if (dropReport && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign uart_tx  = tx_q;
    assign drop_cnt = drop_q;

endmodule
